ucode_loader: RTL and testbench



---
 rtl/ucode_pkg.sv | 25 ++
 rtl/ucode_word_assembler.sv | 33 +++
 rtl/ucode_loader.sv | 111 +++++++++++
 tb/tb_ucode_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode control-store loader.
package ucode_pkg;

  localparam int UCODE_AW       = 8;
  localparam int UCODE_DW       = 64;
  localparam int UCODE_DEPTH    = 256;
  localparam int BYTES_PER_WORD = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SETUP,
    STROBE,
    HOLD,
    VERIFY,
    NEXT,
    DONE
  } loader_state_e;

  // States in which the control store is selected.
  function automatic logic cs_active(loader_state_e s);
    return (s == SETUP) || (s == STROBE) || (s == HOLD) || (s == VERIFY);
  endfunction

endpackage

// File: rtl/ucode_word_assembler.sv
// Big-endian 8-to-64 byte shift register; word_full flags the byte that completes a word.
module ucode_word_assembler
  import ucode_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                shift,
  input  logic [7:0]          byte_in,
  output logic [UCODE_DW-1:0] word,
  output logic                word_full
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] count;

  assign word_full = shift && (count == CW'(BYTES_PER_WORD - 1));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      word  <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift) begin
      count <= count + 1'b1;
      word  <= {word[UCODE_DW-9:0], byte_in};
    end
  end

endmodule

// File: rtl/ucode_loader.sv
// Boot loader: assembles streamed bytes into 64-bit words, writes them to the
// control store with registered active-low strobes, then reads back and compares.
module ucode_loader
  import ucode_pkg::*;
#(
  parameter int WORDS     = 256,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        _ram_cs,
  output logic        _ram_oe,
  output logic        _ram_w,
  output logic [7:0]  ram_addr,
  output logic [63:0] ram_wdata,
  input  logic [63:0] ram_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_addr
);

  localparam logic [UCODE_AW-1:0] LAST_ADDR = UCODE_AW'(WORDS - 1);

  loader_state_e state, state_next;
  logic          start_load;
  logic          accept;
  logic          word_full;
  logic          last_word;
  logic          mismatch;

  assign in_ready   = (state == COLLECT);
  assign accept     = in_ready && in_valid;
  assign start_load = start && ((state == IDLE) || (state == DONE));
  assign last_word  = (ram_addr == LAST_ADDR);
  assign mismatch   = (ram_rdata != ram_wdata);

  ucode_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_load || (state == NEXT)),
    .shift     (accept),
    .byte_in   (in_data),
    .word      (ram_wdata),
    .word_full (word_full)
  );

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = COLLECT;
      COLLECT:    if (word_full) state_next = SETUP;
      SETUP:      state_next = STROBE;
      STROBE:     state_next = HOLD;
      HOLD:       state_next = VERIFY_EN ? VERIFY : NEXT;
      VERIFY:     state_next = NEXT;
      NEXT:       state_next = last_word ? DONE : COLLECT;
      default:    state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they switch
  // cleanly on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      _ram_cs  <= 1'b1;
      _ram_oe  <= 1'b1;
      _ram_w   <= 1'b1;
      ram_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      state   <= state_next;
      _ram_cs <= !cs_active(state_next);
      _ram_oe <= !(state_next == VERIFY);
      _ram_w  <= !(state_next == STROBE);

      if (start_load) begin
        done     <= 1'b0;
        error    <= 1'b0;
        err_addr <= '0;
        ram_addr <= '0;
        busy     <= 1'b1;
      end

      // Only the first mismatch of a load records its address.
      if (state == VERIFY && mismatch) begin
        error <= 1'b1;
        if (!error) err_addr <= ram_addr;
      end

      if (state == NEXT) begin
        if (last_word) begin
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          ram_addr <= ram_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// Directed bench for ucode_loader: a WORDS=4 instance for function tests and a
// WORDS=256 instance under a strobe protocol monitor.
module tb_ucode_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, sel, f2, f3;
  logic [7:0]  in_data;

  logic        ready0, cs0, oe0, w0, busy0, done0, err0;
  logic [7:0]  addr0, ea0;
  logic [63:0] wdata0, rdata0;
  logic        ready1, cs1, oe1, w1, busy1, done1, err1;
  logic [7:0]  addr1, ea1;
  logic [63:0] wdata1, rdata1;

  logic [63:0] mem0 [0:255];
  logic [63:0] mem1 [0:255];

  int n_checks = 0;
  int n_pass   = 0;
  int ready_bad = 0;
  int stab_bad = 0, overlap_bad = 0, wfall = 0;

  always #5 clk = ~clk;

  ucode_loader #(.WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start & ~sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(ready0), ._ram_cs(cs0), ._ram_oe(oe0),
    ._ram_w(w0), .ram_addr(addr0), .ram_wdata(wdata0), .ram_rdata(rdata0),
    .busy(busy0), .done(done0), .error(err0), .err_addr(ea0)
  );

  ucode_loader #(.WORDS(256)) dut256 (
    .clk(clk), .reset(reset), .start(start & sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(ready1), ._ram_cs(cs1), ._ram_oe(oe1),
    ._ram_w(w1), .ram_addr(addr1), .ram_wdata(wdata1), .ram_rdata(rdata1),
    .busy(busy1), .done(done1), .error(err1), .err_addr(ea1)
  );

  // Control-store models: capture on the falling edge of the write strobe.
  always @(negedge w0) if (!cs0) mem0[addr0] <= wdata0;
  always @(negedge w1) if (!cs1) mem1[addr1] <= wdata1;
  assign rdata0 = mem0[addr0] & ~{63'b0, (f2 && addr0 == 8'd2) || (f3 && addr0 == 8'd3)};
  assign rdata1 = mem1[addr1];

  // Views of the instance under test.
  wire        in_ready = sel ? ready1 : ready0;
  wire        cs_v     = sel ? cs1 : cs0;
  wire        oe_v     = sel ? oe1 : oe0;
  wire        w_v      = sel ? w1 : w0;
  wire [7:0]  addr_v   = sel ? addr1 : addr0;
  wire [63:0] wdata_v  = sel ? wdata1 : wdata0;
  wire        busy     = sel ? busy1 : busy0;
  wire        done     = sel ? done1 : done0;
  wire        error    = sel ? err1 : err0;
  wire [7:0]  err_addr = sel ? ea1 : ea0;

  // Protocol monitor on the 256-word instance.
  logic        pcs_low = 1'b0;
  logic [7:0]  paddr;
  logic [63:0] pwdata;
  always @(negedge clk) begin
    if (!cs1 && pcs_low && (addr1 != paddr || wdata1 != pwdata)) stab_bad++;
    if (!w1 && !oe1) overlap_bad++;
    pcs_low = !cs1;
    paddr   = addr1;
    pwdata  = wdata1;
  end
  always @(negedge w1) wfall++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Pulse start, then stream bytes base, base+1, ... until done (or until
  // STROBE of word 1 when stop_strobe1 is set). n counts edges after start.
  task automatic run_load(input bit toggle, input int base, input int start_at,
                          input bit stop_strobe1, input int limit, output int n);
    int idx;
    bit ph, pv, pr;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_error", 64'(error), 64'd0);
    check("start_err_addr", 64'(err_addr), 64'd0);
    idx = 0; ph = 1'b0; n = 0;
    while (n < limit) begin
      if (in_ready && (!toggle || ph)) begin
        in_valid = 1'b1;
        in_data  = 8'(base + idx);
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready) ph = !ph;
      if (in_ready && (!busy || !cs_v)) ready_bad++;
      start = (n == start_at);
      pv = in_valid;
      pr = in_ready;
      @(negedge clk);
      n++;
      if (pv && pr) idx++;
      if (done) break;
      if (stop_strobe1 && !w_v && addr_v == 8'd1) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    sel = 1'b0; reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    f2 = 1'b0; f3 = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    check("rst_cs", 64'(cs_v), 64'd1);
    check("rst_oe", 64'(oe_v), 64'd1);
    check("rst_w", 64'(w_v), 64'd1);
    check("rst_addr", 64'(addr_v), 64'd0);
    check("rst_wdata", wdata_v, 64'd0);
    @(negedge clk);
    check("rst_start_ignored", 64'(busy), 64'd0);

    // Back-to-back bytes 00..1F.
    run_load(1'b0, 0, -1, 1'b0, 200, n);
    check("b2b_cycles", 64'(n), 64'd52);
    check("b2b_ram0", mem0[0], 64'h0001020304050607);
    check("b2b_ram1", mem0[1], 64'h08090A0B0C0D0E0F);
    check("b2b_ram2", mem0[2], 64'h1011121314151617);
    check("b2b_ram3", mem0[3], 64'h18191A1B1C1D1E1F);
    check("b2b_error", 64'(error), 64'd0);
    check("b2b_busy", 64'(busy), 64'd0);
    check("b2b_addr_held", 64'(addr_v), 64'd3);

    // in_valid toggling 0/1 during COLLECT, bytes 40..5F.
    run_load(1'b1, 8'h40, -1, 1'b0, 300, n);
    check("tog_cycles", 64'(n), 64'd84);
    check("tog_ram0", mem0[0], 64'h4041424344454647);
    check("tog_ram3", mem0[3], 64'h58595A5B5C5D5E5F);
    check("tog_ready_outside_collect", 64'(ready_bad), 64'd0);

    // Readback faults at addresses 2 and 3; only the first is recorded.
    f2 = 1'b1; f3 = 1'b1;
    run_load(1'b0, 8'h80, -1, 1'b0, 200, n);
    f2 = 1'b0; f3 = 1'b0;
    check("flt_done", 64'(done), 64'd1);
    check("flt_error", 64'(error), 64'd1);
    check("flt_err_addr", 64'(err_addr), 64'd2);
    check("flt_ram3", mem0[3], 64'h98999A9B9C9D9E9F);

    // Start from DONE clears status (checked in run_load); start in COLLECT ignored.
    run_load(1'b0, 8'hC0, 3, 1'b0, 200, n);
    check("sic_cycles", 64'(n), 64'd52);
    check("sic_ram1", mem0[1], 64'hC8C9CACBCCCDCECF);
    check("sic_error", 64'(error), 64'd0);

    // Reset during STROBE of word 1.
    run_load(1'b0, 8'h20, -1, 1'b1, 200, n);
    check("rs_strobe_reached", 64'(n), 64'd22);
    reset = 1'b1;
    @(negedge clk);
    check("rs_w", 64'(w_v), 64'd1);
    check("rs_cs", 64'(cs_v), 64'd1);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_addr", 64'(addr_v), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd0);
    check("rs_ram1_captured", mem0[1], 64'h28292A2B2C2D2E2F);
    reset = 1'b0;
    run_load(1'b0, 0, -1, 1'b0, 200, n);
    check("rs_reload_cycles", 64'(n), 64'd52);
    check("rs_reload_ram0", mem0[0], 64'h0001020304050607);
    check("rs_reload_ram1", mem0[1], 64'h08090A0B0C0D0E0F);

    // Full 256-word load under the protocol monitor.
    sel = 1'b1;
    run_load(1'b0, 0, -1, 1'b0, 4000, n);
    check("full_cycles", 64'(n), 64'd3328);
    check("full_w_falls", 64'(wfall), 64'd256);
    check("full_stable", 64'(stab_bad), 64'd0);
    check("full_w_oe_overlap", 64'(overlap_bad), 64'd0);
    check("full_ram0", mem1[0], 64'h0001020304050607);
    check("full_ram255", mem1[255], 64'hF8F9FAFBFCFDFEFF);
    check("full_error", 64'(error), 64'd0);
    check("full_addr", 64'(addr_v), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
